// File: rtl/uart_transceiver_core_if.sv
// Byte-level side of the UART transceiver: received byte/strobes and transmit request.
// master = byte-level client (console printer, register file), slave = the transceiver core.
interface uart_transceiver_core_if;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_break;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_done;

  modport master (
    input  rx_data, rx_done, rx_break, tx_done,
    output tx_data, tx_wr
  );

  modport slave (
    output rx_data, rx_done, rx_break, tx_done,
    input  tx_data, tx_wr
  );
endinterface

// File: rtl/uart_transceiver_core.sv
// Full-duplex 8N1 UART, 16x oversampling, runtime baud divisor.
// Optional build macro UART_RX_GLITCH_FILTER_EN: 2-of-3 majority voting on every RX bit.
module uart_transceiver_core (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    uart_rx,
  output logic                    uart_tx,
  input  logic [15:0]             divisor,
  uart_transceiver_core_if.slave  bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_st_e;

  // Oversample tick generator
  logic [15:0] tick_cnt;
  logic        tick;

  assign tick = (tick_cnt == 16'd0);

  always_ff @(posedge sys_clk) begin
    if (sys_rst)
      tick_cnt <= 16'd0;
    else if (tick)
      tick_cnt <= (divisor == 16'd0) ? 16'd0 : divisor - 16'd1;
    else
      tick_cnt <= tick_cnt - 16'd1;
  end

  // RX input synchroniser and falling-edge detect
  logic rx_meta, rx_sync, rx_prev;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  uart_st_e    rx_state, rx_state_nxt;
  logic [3:0]  rx_phase;
  logic [2:0]  rx_bit_cnt;
  logic [7:0]  rx_shift;
  logic        rx_bit, rx_fall, rx_decide;
  logic        rx_start_clr, rx_shift_en, rx_commit, rx_brk;

`ifdef UART_RX_GLITCH_FILTER_EN
  // Phase is pre-loaded to 1 so the phase-8 vote lands on the same tick as the unfiltered decision.
  localparam logic [3:0] RX_PH_INIT   = 4'd1;
  localparam logic [3:0] RX_DECIDE_PH = 4'd8;

  logic rx_samp6, rx_samp7;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always_ff @(posedge sys_clk) begin
    if (tick && rx_phase == 4'd6) rx_samp6 <= rx_sync;
    if (tick && rx_phase == 4'd7) rx_samp7 <= rx_sync;
  end

  assign rx_bit = maj3(rx_samp6, rx_samp7, rx_sync);
`else
  localparam logic [3:0] RX_PH_INIT   = 4'd0;
  localparam logic [3:0] RX_DECIDE_PH = 4'd7;

  assign rx_bit = rx_sync;
`endif

  assign rx_fall   = rx_prev & ~rx_sync;
  assign rx_decide = tick && (rx_phase == RX_DECIDE_PH);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) rx_state <= ST_IDLE;
    else         rx_state <= rx_state_nxt;
  end

  always_comb begin
    rx_state_nxt = rx_state;
    case (rx_state)
      ST_IDLE:  if (rx_fall) rx_state_nxt = ST_START;
      ST_START: if (rx_decide) rx_state_nxt = rx_bit ? ST_IDLE : ST_DATA;
      ST_DATA:  if (rx_decide && rx_bit_cnt == 3'd7) rx_state_nxt = ST_STOP;
      ST_STOP:  if (rx_decide) rx_state_nxt = ST_IDLE;
      default:  rx_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    rx_start_clr = 1'b0;
    rx_shift_en  = 1'b0;
    rx_commit    = 1'b0;
    rx_brk       = 1'b0;
    case (rx_state)
      ST_IDLE: rx_start_clr = rx_fall;
      ST_DATA: rx_shift_en  = rx_decide;
      ST_STOP: begin
        rx_commit = rx_decide & rx_bit;
        rx_brk    = rx_decide & ~rx_bit & (rx_shift == 8'h00);
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rx_phase   <= 4'd0;
      rx_bit_cnt <= 3'd0;
    end else begin
      if (rx_start_clr)  rx_phase <= RX_PH_INIT;
      else if (tick)     rx_phase <= rx_phase + 4'd1;
      if (rx_start_clr)     rx_bit_cnt <= 3'd0;
      else if (rx_shift_en) rx_bit_cnt <= rx_bit_cnt + 3'd1;
    end
  end

  // LSB arrives first, so bits enter at the top and move down
  always_ff @(posedge sys_clk) begin
    if (rx_shift_en) rx_shift <= {rx_bit, rx_shift[7:1]};
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      bus.rx_data  <= 8'h00;
      bus.rx_done  <= 1'b0;
      bus.rx_break <= 1'b0;
    end else begin
      bus.rx_done  <= rx_commit;
      bus.rx_break <= rx_brk;
      if (rx_commit) bus.rx_data <= rx_shift;
    end
  end

  // TX engine
  uart_st_e    tx_state, tx_state_nxt;
  logic        tx_pend;
  logic [3:0]  tx_phase;
  logic [2:0]  tx_bit_cnt;
  logic [7:0]  tx_shift;
  logic        tx_bit_end, tx_accept, tx_launch, tx_shift_en, tx_finish, tx_line_d;

  assign tx_bit_end = tick && (tx_phase == 4'd15);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) tx_state <= ST_IDLE;
    else         tx_state <= tx_state_nxt;
  end

  always_comb begin
    tx_state_nxt = tx_state;
    case (tx_state)
      ST_IDLE:  if (tx_pend && tick) tx_state_nxt = ST_START;
      ST_START: if (tx_bit_end) tx_state_nxt = ST_DATA;
      ST_DATA:  if (tx_bit_end && tx_bit_cnt == 3'd7) tx_state_nxt = ST_STOP;
      ST_STOP:  if (tx_bit_end) tx_state_nxt = ST_IDLE;
      default:  tx_state_nxt = ST_IDLE;
    endcase
  end

  // Line level is derived from the next state so it switches together with the FSM
  always_comb begin
    tx_accept   = 1'b0;
    tx_launch   = 1'b0;
    tx_shift_en = 1'b0;
    tx_finish   = 1'b0;
    case (tx_state)
      ST_IDLE: begin
        tx_accept = bus.tx_wr & ~tx_pend;
        tx_launch = tx_pend & tick;
      end
      ST_DATA: tx_shift_en = tx_bit_end;
      ST_STOP: tx_finish   = tx_bit_end;
      default: ;
    endcase
    case (tx_state_nxt)
      ST_START: tx_line_d = 1'b0;
      ST_DATA:  tx_line_d = tx_shift_en ? tx_shift[1] : tx_shift[0];
      default:  tx_line_d = 1'b1;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      tx_pend     <= 1'b0;
      tx_phase    <= 4'd0;
      tx_bit_cnt  <= 3'd0;
      uart_tx     <= 1'b1;
      bus.tx_done <= 1'b0;
    end else begin
      if (tx_accept)      tx_pend <= 1'b1;
      else if (tx_launch) tx_pend <= 1'b0;
      if (tx_launch)      tx_phase <= 4'd0;
      else if (tick)      tx_phase <= tx_phase + 4'd1;
      if (tx_launch)        tx_bit_cnt <= 3'd0;
      else if (tx_shift_en) tx_bit_cnt <= tx_bit_cnt + 3'd1;
      uart_tx     <= tx_line_d;
      bus.tx_done <= tx_finish;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (tx_accept)        tx_shift <= bus.tx_data;
    else if (tx_shift_en) tx_shift <= {1'b0, tx_shift[7:1]};
  end

endmodule

// File: tb/tb_uart_transceiver_core.sv
// Directed bench for uart_transceiver_core at divisor 43 (688 clk per bit).
module tb_uart_transceiver_core;

  localparam int BIT_CLK = 688;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        uart_rx;
  logic        uart_tx;
  logic [15:0] divisor;
  logic        rx_drv;
  logic        loop_en;

  uart_transceiver_core_if bus_if ();

  uart_transceiver_core dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .uart_rx (uart_rx),
    .uart_tx (uart_tx),
    .divisor (divisor),
    .bus     (bus_if)
  );

  assign uart_rx = loop_en ? uart_tx : rx_drv;

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse monitor
  longint      cyc = 0;
  int          rx_done_cnt = 0, rx_brk_cnt = 0, tx_done_cnt = 0, wide_cnt = 0;
  logic [7:0]  rx_q[$];
  longint      tx_fall_q[$];
  longint      tx_done_cyc = 0;
  logic        prev_done = 1'b0, prev_tx = 1'b1;

  always @(negedge sys_clk) begin
    cyc++;
    if (bus_if.rx_done === 1'b1) begin
      rx_done_cnt++;
      rx_q.push_back(bus_if.rx_data);
      if (prev_done) wide_cnt++;
    end
    if (bus_if.rx_break === 1'b1) rx_brk_cnt++;
    if (bus_if.tx_done === 1'b1) begin
      tx_done_cnt++;
      tx_done_cyc = cyc;
    end
    if (prev_tx === 1'b1 && uart_tx === 1'b0) tx_fall_q.push_back(cyc);
    prev_done = bus_if.rx_done;
    prev_tx   = uart_tx;
  end

  function automatic logic [31:0] q_at(input int idx);
    if (idx < rx_q.size()) return {24'h0, rx_q[idx]};
    return 32'hDEAD;
  endfunction

  task automatic send_rx(input logic [7:0] b, input bit spike);
    rx_drv = 1'b0;
    repeat (BIT_CLK) @(negedge sys_clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      if (spike && i == 3) begin
        repeat (330) @(negedge sys_clk);
        rx_drv = ~b[i];
        repeat (30) @(negedge sys_clk);
        rx_drv = b[i];
        repeat (BIT_CLK - 360) @(negedge sys_clk);
      end else begin
        repeat (BIT_CLK) @(negedge sys_clk);
      end
    end
    rx_drv = 1'b1;
    repeat (BIT_CLK) @(negedge sys_clk);
  endtask

  task automatic tx_write(input logic [7:0] b);
    bus_if.tx_data = b;
    bus_if.tx_wr   = 1'b1;
    @(negedge sys_clk);
    bus_if.tx_wr   = 1'b0;
  endtask

  task automatic wait_tx_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge sys_clk);
      if (bus_if.tx_done === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int         n0, q0, t0, b0, f0;
    bit         ok;
    logic [9:0] frame;
    logic [7:0] lb [4];

    lb = '{8'h00, 8'hFF, 8'h5A, 8'h81};
    sys_rst = 1'b1;
    rx_drv  = 1'b1;
    loop_en = 1'b0;
    divisor = 16'd43;
    bus_if.tx_data = 8'h00;
    bus_if.tx_wr   = 1'b0;
    repeat (3) @(negedge sys_clk);
    check_val("rst_uart_tx",  uart_tx,         1'b1);
    check_val("rst_rx_done",  bus_if.rx_done,  1'b0);
    check_val("rst_tx_done",  bus_if.tx_done,  1'b0);
    check_val("rst_rx_data",  bus_if.rx_data,  8'h00);
    check_val("rst_rx_break", bus_if.rx_break, 1'b0);
    sys_rst = 1'b0;
    repeat (20) @(negedge sys_clk);

    // Two received frames separated by an idle gap
    n0 = rx_done_cnt; q0 = rx_q.size(); b0 = rx_brk_cnt;
    send_rx(8'h55, 1'b0);
    repeat (1000) @(negedge sys_clk);
    send_rx(8'h0A, 1'b0);
    repeat (300) @(negedge sys_clk);
    check_val("rx_done_count", rx_done_cnt - n0, 2);
    check_val("rx_byte0",      q_at(q0),     8'h55);
    check_val("rx_byte1",      q_at(q0 + 1), 8'h0A);
    check_val("rx_done_width", wide_cnt,      0);
    check_val("rx_data_held",  bus_if.rx_data, 8'h0A);
    check_val("rx_no_break",   rx_brk_cnt - b0, 0);

    // Transmit 0xA3 and check every level edge-to-edge
    t0 = tx_done_cnt; f0 = tx_fall_q.size();
    frame = {1'b1, 8'hA3, 1'b0};
    tx_write(8'hA3);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (uart_tx === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge sys_clk);
    end
    check_val("tx_start_seen", ok, 1'b1);
    for (int k = 0; k < 10; k++) begin
      check_val($sformatf("tx_lvl%0d_head", k), uart_tx, frame[k]);
      repeat (BIT_CLK - 1) @(negedge sys_clk);
      check_val($sformatf("tx_lvl%0d_tail", k), uart_tx, frame[k]);
      @(negedge sys_clk);
    end
    repeat (100) @(negedge sys_clk);
    check_val("tx_done_count", tx_done_cnt - t0, 1);
    if (tx_fall_q.size() > f0)
      check_val("tx_done_latency", 32'(tx_done_cyc - tx_fall_q[f0]), 32'd6880);
    else
      check_val("tx_done_latency", 32'hFFFF_FFFF, 32'd6880);

    // Loopback, back-to-back frames, one write issued mid-frame
    loop_en = 1'b1;
    n0 = rx_done_cnt; q0 = rx_q.size(); t0 = tx_done_cnt;
    tx_write(lb[0]);
    repeat (3000) @(negedge sys_clk);
    tx_write(8'hEE);
    for (int i = 1; i < 4; i++) begin
      wait_tx_done(8000, ok);
      check_val($sformatf("lb_tx_done%0d", i), ok, 1'b1);
      bus_if.tx_data = lb[i];
      bus_if.tx_wr   = 1'b1;
      @(negedge sys_clk);
      bus_if.tx_wr   = 1'b0;
    end
    wait_tx_done(8000, ok);
    check_val("lb_tx_done_last", ok, 1'b1);
    repeat (50) @(negedge sys_clk);
    check_val("lb_rx_count", rx_done_cnt - n0, 4);
    check_val("lb_tx_count", tx_done_cnt - t0, 4);
    for (int i = 0; i < 4; i++)
      check_val($sformatf("lb_byte%0d", i), q_at(q0 + i), {24'h0, lb[i]});
    check_val("lb_done_width", wide_cnt, 0);
    rx_drv  = 1'b1;
    loop_en = 1'b0;
    repeat (100) @(negedge sys_clk);

    // Line break: 12 bit times low
    n0 = rx_done_cnt; b0 = rx_brk_cnt;
    rx_drv = 1'b0;
    repeat (12 * BIT_CLK) @(negedge sys_clk);
    rx_drv = 1'b1;
    repeat (1500) @(negedge sys_clk);
    check_val("brk_count",     rx_brk_cnt - b0, 1);
    check_val("brk_no_done",   rx_done_cnt - n0, 0);
    check_val("brk_data_kept", bus_if.rx_data, 8'h81);

    // Short low glitch on an idle line
    n0 = rx_done_cnt; b0 = rx_brk_cnt;
    rx_drv = 1'b0;
    repeat (200) @(negedge sys_clk);
    rx_drv = 1'b1;
    repeat (1500) @(negedge sys_clk);
    check_val("glitch_no_done",  rx_done_cnt - n0, 0);
    check_val("glitch_no_break", rx_brk_cnt - b0, 0);
    check_val("glitch_data",     bus_if.rx_data, 8'h81);

`ifdef UART_RX_GLITCH_FILTER_EN
    n0 = rx_done_cnt;
    send_rx(8'h00, 1'b1);
    repeat (300) @(negedge sys_clk);
    check_val("filt_done",  rx_done_cnt - n0, 1);
    check_val("filt_data",  bus_if.rx_data, 8'h00);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
